// File: rtl/sda_kernel_ctrl_multi.sv
// rtl/sda_kernel_ctrl_multi.sv - ap_ctrl register block driving NUM_ACTIONS go/done action channels
// Register accesses are registered: sample on one edge, ack (and side effects) on the next cycle.
`timescale 1ns/1ps
module sda_kernel_ctrl_multi #(
  parameter int NUM_ACTIONS    = 2,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      reg_req,
  output logic                      reg_ack,
  input  logic                      reg_write_en,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]               reg_wdata,
  output logic [31:0]               reg_rdata,
  output logic [NUM_ACTIONS-1:0]    go_r,
  input  logic [NUM_ACTIONS-1:0]    go_a,
  input  logic [NUM_ACTIONS-1:0]    done_r,
  output logic [NUM_ACTIONS-1:0]    done_a,
  output logic                      interrupt
);

  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CTRL   = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_GIE    = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_IER    = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ISR    = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CHEN   = REG_ADDR_WIDTH'(4);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CHSTAT = REG_ADDR_WIDTH'(5);

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_FINISH} g_state_e;
  typedef enum logic [2:0] {C_IDLE, C_GO_REQ, C_GO_RTZ, C_WAIT, C_DONE_ACK, C_FIN} c_state_e;

  g_state_e g_state_q, g_state_d;
  c_state_e c_state_q [NUM_ACTIONS];
  c_state_e c_state_d [NUM_ACTIONS];

  logic ap_start_q, ap_start_d;
  logic ap_done_q, ap_done_d;
  logic ap_idle_q, ap_idle_d;
  logic ap_ready_q, ap_ready_d;
  logic auto_restart_q, auto_restart_d;
  logic gie_q, gie_d;
  logic [1:0] ier_q, ier_d;
  logic [1:0] isr_q, isr_d;
  logic [NUM_ACTIONS-1:0] chen_q, chen_d;
  logic [NUM_ACTIONS-1:0] run_mask_q, run_mask_d;
  logic [NUM_ACTIONS-1:0] chstat_q, chstat_d;
  logic interrupt_q, interrupt_d;

  logic ack_q, ack_d;
  logic req_we_q, req_we_d;
  logic [REG_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        wr_ack;
  logic        rd_ack;
  logic        busy;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^req_wdata_q;

  // Read data is captured from the register state seen at the sampling edge.
  always_comb begin
    rd_mux = 32'd0;
    case (reg_addr)
      ADDR_CTRL:   rd_mux = {24'd0, auto_restart_q, 3'd0, ap_ready_q, ap_idle_q, ap_done_q, ap_start_q};
      ADDR_GIE:    rd_mux = {31'd0, gie_q};
      ADDR_IER:    rd_mux = {30'd0, ier_q};
      ADDR_ISR:    rd_mux = {30'd0, isr_q};
      ADDR_CHEN:   rd_mux = 32'(chen_q);
      ADDR_CHSTAT: rd_mux = 32'(chstat_q);
      default:     rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    accept      = reg_req & ~ack_q;
    ack_d       = accept;
    req_we_d    = accept ? reg_write_en : req_we_q;
    req_addr_d  = accept ? reg_addr : req_addr_q;
    req_wdata_d = accept ? reg_wdata : req_wdata_q;
    rdata_d     = (accept && !reg_write_en) ? rd_mux : 32'd0;
  end

  assign wr_ack = ack_q & req_we_q;
  assign rd_ack = ack_q & ~req_we_q;
  assign busy   = (g_state_q != G_IDLE) | ap_start_q;

  always_comb begin
    g_state_d      = g_state_q;
    ap_start_d     = ap_start_q;
    ap_done_d      = ap_done_q;
    ap_idle_d      = ap_idle_q;
    ap_ready_d     = ap_ready_q;
    auto_restart_d = auto_restart_q;
    gie_d          = gie_q;
    ier_d          = ier_q;
    isr_d          = isr_q;
    chen_d         = chen_q;
    run_mask_d     = run_mask_q;
    chstat_d       = chstat_q;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      c_state_d[i] = c_state_q[i];
    end

    if (wr_ack) begin
      case (req_addr_q)
        ADDR_CTRL: begin
          auto_restart_d = req_wdata_q[7];
          if (req_wdata_q[0] && !busy) ap_start_d = 1'b1;
        end
        ADDR_GIE:  gie_d = req_wdata_q[0];
        ADDR_IER:  ier_d = req_wdata_q[1:0];
        ADDR_ISR:  isr_d = isr_q ^ req_wdata_q[1:0];
        ADDR_CHEN: if (!busy) chen_d = req_wdata_q[NUM_ACTIONS-1:0];
        default: ;
      endcase
    end

    if (rd_ack && (req_addr_q == ADDR_CTRL)) begin
      ap_done_d  = 1'b0;
      ap_ready_d = 1'b0;
    end

    for (int i = 0; i < NUM_ACTIONS; i++) begin
      case (c_state_q[i])
        C_IDLE:     if (g_state_q == G_RUN && run_mask_q[i]) c_state_d[i] = C_GO_REQ;
        C_GO_REQ:   if (go_a[i]) c_state_d[i] = C_GO_RTZ;
        C_GO_RTZ:   if (!go_a[i]) c_state_d[i] = C_WAIT;
        C_WAIT:     if (done_r[i]) c_state_d[i] = C_DONE_ACK;
        C_DONE_ACK: begin
          if (!done_r[i]) begin
            c_state_d[i] = C_FIN;
            chstat_d[i]  = 1'b1;
          end
        end
        C_FIN:      if (g_state_q != G_RUN) c_state_d[i] = C_IDLE;
        default:    c_state_d[i] = C_IDLE;
      endcase
    end

    // FSM set events come last so they win over clear-on-read and toggle writes.
    case (g_state_q)
      G_IDLE: begin
        if (ap_start_q) begin
          run_mask_d = chen_q;
          chstat_d   = '0;
          ap_idle_d  = 1'b0;
          g_state_d  = G_RUN;
        end
      end
      G_RUN: begin
        if (chstat_q == run_mask_q) g_state_d = G_FINISH;
      end
      G_FINISH: begin
        ap_done_d  = 1'b1;
        ap_ready_d = 1'b1;
        isr_d      = 2'b11;
        if (auto_restart_q) begin
          run_mask_d = chen_q;
          chstat_d   = '0;
          g_state_d  = G_RUN;
        end else begin
          ap_start_d = 1'b0;
          ap_idle_d  = 1'b1;
          g_state_d  = G_IDLE;
        end
      end
      default: g_state_d = G_IDLE;
    endcase

    interrupt_d = gie_d & |(isr_d & ier_d);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      g_state_q      <= G_IDLE;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
        c_state_q[i] <= C_IDLE;
      end
      ap_start_q     <= 1'b0;
      ap_done_q      <= 1'b0;
      ap_idle_q      <= 1'b1;
      ap_ready_q     <= 1'b0;
      auto_restart_q <= 1'b0;
      gie_q          <= 1'b0;
      ier_q          <= 2'b00;
      isr_q          <= 2'b00;
      chen_q         <= '1;
      run_mask_q     <= '0;
      chstat_q       <= '0;
      interrupt_q    <= 1'b0;
      ack_q          <= 1'b0;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= 32'd0;
      rdata_q        <= 32'd0;
    end else begin
      g_state_q      <= g_state_d;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
        c_state_q[i] <= c_state_d[i];
      end
      ap_start_q     <= ap_start_d;
      ap_done_q      <= ap_done_d;
      ap_idle_q      <= ap_idle_d;
      ap_ready_q     <= ap_ready_d;
      auto_restart_q <= auto_restart_d;
      gie_q          <= gie_d;
      ier_q          <= ier_d;
      isr_q          <= isr_d;
      chen_q         <= chen_d;
      run_mask_q     <= run_mask_d;
      chstat_q       <= chstat_d;
      interrupt_q    <= interrupt_d;
      ack_q          <= ack_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      rdata_q        <= rdata_d;
    end
  end

  // Handshake outputs decode registered state only, so reset drops them at once.
  always_comb begin
    go_r   = '0;
    done_a = '0;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      go_r[i]   = (c_state_q[i] == C_GO_REQ);
      done_a[i] = (c_state_q[i] == C_DONE_ACK);
    end
  end

  assign reg_ack   = ack_q;
  assign reg_rdata = rdata_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_sda_kernel_ctrl_multi.sv
// tb/tb_sda_kernel_ctrl_multi.sv - scoreboard bench for sda_kernel_ctrl_multi
// Action cores are modelled with fixed done latencies of 3 and 10 cycles.
`timescale 1ns/1ps
module tb_sda_kernel_ctrl_multi;
  localparam int NA = 2;
  localparam int AW = 4;
  localparam logic [AW-1:0] A_CTRL   = 4'd0;
  localparam logic [AW-1:0] A_GIE    = 4'd1;
  localparam logic [AW-1:0] A_IER    = 4'd2;
  localparam logic [AW-1:0] A_ISR    = 4'd3;
  localparam logic [AW-1:0] A_CHEN   = 4'd4;
  localparam logic [AW-1:0] A_CHSTAT = 4'd5;
  localparam logic [AW-1:0] A_BAD    = 4'd7;

  logic clk = 1'b0;
  logic rst_n;
  logic reg_req, reg_ack, reg_write_en;
  logic [AW-1:0] reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [NA-1:0] go_r, go_a, done_r, done_a;
  logic interrupt;

  always #5 clk = ~clk;

  sda_kernel_ctrl_multi #(.NUM_ACTIONS(NA), .REG_ADDR_WIDTH(AW)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .reg_req(reg_req), .reg_ack(reg_ack), .reg_write_en(reg_write_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .go_r(go_r), .go_a(go_a), .done_r(done_r), .done_a(done_a),
    .interrupt(interrupt)
  );

  typedef struct {
    string       name;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int go0_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (go_r[0]) go0_cnt++;
    if (reg_ack === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) chk(e.name, reg_rdata, e.data);
      end
    end
  end

  task automatic access(input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                        input bit c, input logic [31:0] e, input string nm);
    exp_t x;
    bit got;
    x.name = nm; x.chk = c; x.data = e;
    sb.push_back(x);
    reg_write_en = we; reg_addr = a; reg_wdata = d; reg_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (reg_ack) got = 1'b1;
    end
    reg_req = 1'b0;
    if (!got) chk({nm, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    access(1'b1, a, d, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] e, input string nm);
    access(1'b0, a, 32'd0, 1'b1, e, nm);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (done_a[i]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_go(input logic [NA-1:0] pat, input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (go_r === pat) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) chk({nm, "_timeout"}, 32'(go_r), 32'(pat));
  endtask

  initial begin
    int st[NA];
    int cnt[NA];
    int dly[NA];
    dly = '{3, 10};
    go_a = '0;
    done_r = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NA; i++) begin
        if (!rst_n) begin
          st[i] = 0; go_a[i] = 1'b0; done_r[i] = 1'b0;
        end else begin
          case (st[i])
            0: if (go_r[i]) begin go_a[i] = 1'b1; st[i] = 1; end
            1: if (!go_r[i]) begin go_a[i] = 1'b0; cnt[i] = dly[i]; st[i] = 2; end
            2: begin
              cnt[i]--;
              if (cnt[i] == 0) begin done_r[i] = 1'b1; st[i] = 3; end
            end
            3: if (done_a[i]) begin done_r[i] = 1'b0; st[i] = 0; end
            default: st[i] = 0;
          endcase
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst_n = 1'b0; reg_req = 1'b0; reg_write_en = 1'b0; reg_addr = '0; reg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go_r", 32'(go_r), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    chk("rst_reg_ack", 32'(reg_ack), 32'd0);
    rst_n = 1'b1;
    cycles(1);
    rd(A_CTRL, 32'h4, "rst_ctrl");
    rd(A_CHEN, 32'h3, "rst_chen");
    rd(A_ISR, 32'h0, "rst_isr");
    rd(A_IER, 32'h0, "rst_ier");
    rd(A_GIE, 32'h0, "rst_gie");
    wr(A_BAD, 32'hFFFF_FFFF);
    rd(A_BAD, 32'h0, "bad_addr");

    // single run, both channels
    wr(A_CTRL, 32'h1);
    wait_go(2'b11, "go_both");
    wait_done(0, "done0");
    cycles(3);
    rd(A_CHSTAT, 32'h1, "chstat_mid");
    wait_done(1, "done1");
    cycles(5);
    rd(A_CHSTAT, 32'h3, "chstat_end");
    rd(A_CTRL, 32'hE, "ctrl_done");
    rd(A_CTRL, 32'h4, "ctrl_cleared");

    // interrupt path
    wr(A_ISR, 32'h3);
    rd(A_ISR, 32'h0, "isr_toggle_clear");
    wr(A_GIE, 32'h1);
    wr(A_IER, 32'h1);
    chk("irq_idle", 32'(interrupt), 32'd0);
    wr(A_CTRL, 32'h1);
    wait_done(1, "irq_done1");
    cycles(2);
    chk("irq_in_finish", 32'(interrupt), 32'd0);
    cycles(1);
    chk("irq_after_finish", 32'(interrupt), 32'd1);
    wr(A_ISR, 32'h1);
    chk("irq_ack_cycle", 32'(interrupt), 32'd1);
    cycles(1);
    chk("irq_cleared", 32'(interrupt), 32'd0);
    rd(A_ISR, 32'h2, "isr_ready_left");
    wr(A_ISR, 32'h2);
    wr(A_GIE, 32'h0);
    rd(A_CTRL, 32'hE, "ctrl_irq_run");

    // channel mask
    wr(A_CHEN, 32'h2);
    rd(A_CHEN, 32'h2, "chen_wr");
    snap = go0_cnt;
    wr(A_CTRL, 32'h1);
    wait_go(2'b10, "go_ch1_only");
    wr(A_CHEN, 32'h0);
    rd(A_CHEN, 32'h2, "chen_locked");
    wait_done(1, "mask_done1");
    cycles(5);
    chk("go0_masked", 32'(go0_cnt - snap), 32'd0);
    rd(A_CHSTAT, 32'h2, "chstat_ch1");
    rd(A_CTRL, 32'hE, "ctrl_mask_run");
    wr(A_CHEN, 32'h3);

    // auto-restart: next GO_REQ two cycles after FINISH, no IDLE in between
    wr(A_CTRL, 32'h81);
    wait_done(1, "ar_done1");
    cycles(3);
    chk("ar_no_go_yet", 32'(go_r), 32'd0);
    cycles(1);
    chk("ar_go_back2back", 32'(go_r), 32'd3);
    rd(A_CTRL, 32'h8B, "ctrl_ar_done");
    rd(A_CTRL, 32'h81, "ctrl_ar_cleared");
    wr(A_CTRL, 32'h0);
    rd(A_CTRL, 32'h1, "ctrl_ar_stopping");
    wait_done(1, "ar_done2");
    cycles(5);
    rd(A_CTRL, 32'hE, "ctrl_ar_final");
    rd(A_CTRL, 32'h4, "ctrl_ar_idle");

    // read whose ack cycle coincides with FINISH
    wr(A_CTRL, 32'h1);
    wait_done(1, "race_done1");
    cycles(1);
    rd(A_CTRL, 32'h1, "ctrl_race_read");
    rd(A_CTRL, 32'hE, "ctrl_race_next");
    rd(A_CTRL, 32'h4, "ctrl_race_clr");

    // reset during GO_REQ
    wr(A_CTRL, 32'h1);
    wait_go(2'b11, "go_before_rst");
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_go_r", 32'(go_r), 32'd0);
    chk("rst_mid_done_a", 32'(done_a), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(1);
    rd(A_CTRL, 32'h4, "ctrl_after_rst");
    rd(A_ISR, 32'h0, "isr_after_rst");
    rd(A_CHEN, 32'h3, "chen_after_rst");
    cycles(5);
    chk("go_after_rst", 32'(go_r), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
